stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button conditioning and run/lap/clear sequencer for the stopwatch

module stopwatch_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            level      <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            level_q <= level;
            // Count consecutive cycles of disagreement; any agreement restarts the count.
            if (sync_2 != level) begin
                if (stable_cnt == CNT_MAX) begin
                    level      <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign evt = level & ~level_q;
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] cnt_d0,
    input  logic [3:0] cnt_d1,
    input  logic [3:0] cnt_d2,
    input  logic [3:0] cnt_d3,
    output logic       run,
    output logic       clr,
    output logic [3:0] disp_d0,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d3,
    output logic       lap_active,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_nxt;
    logic       clr_nxt;
    logic       lap_load;
    logic       ss_evt;
    logic       lr_evt;
    logic [3:0] lap_d0;
    logic [3:0] lap_d1;
    logic [3:0] lap_d2;
    logic [3:0] lap_d3;

    stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_ss),
        .evt     (ss_evt)
    );

    stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_lr),
        .evt     (lr_evt)
    );

    // Start/stop has priority: a simultaneous lap/reset press is dropped.
    always_comb begin
        state_nxt = state_q;
        clr_nxt   = 1'b0;
        lap_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_evt) begin
                    state_nxt = RUNNING;
                end else if (lr_evt) begin
                    clr_nxt = 1'b1;
                end
            end
            RUNNING: begin
                if (ss_evt) begin
                    state_nxt = PAUSED;
                end else if (lr_evt) begin
                    state_nxt = LAP;
                    lap_load  = 1'b1;
                end
            end
            LAP: begin
                if (ss_evt) begin
                    state_nxt = PAUSED;
                end else if (lr_evt) begin
                    state_nxt = RUNNING;
                end
            end
            PAUSED: begin
                if (ss_evt) begin
                    state_nxt = RUNNING;
                end else if (lr_evt) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            run        <= 1'b0;
            clr        <= 1'b0;
            lap_active <= 1'b0;
            lap_d0     <= 4'd0;
            lap_d1     <= 4'd0;
            lap_d2     <= 4'd0;
            lap_d3     <= 4'd0;
            disp_d0    <= 4'd0;
            disp_d1    <= 4'd0;
            disp_d2    <= 4'd0;
            disp_d3    <= 4'd0;
        end else begin
            state_q    <= state_nxt;
            run        <= (state_nxt == RUNNING) || (state_nxt == LAP);
            clr        <= clr_nxt;
            lap_active <= (state_nxt == LAP);
            if (lap_load) begin
                lap_d0 <= cnt_d0;
                lap_d1 <= cnt_d1;
                lap_d2 <= cnt_d2;
                lap_d3 <= cnt_d3;
            end
            // On the capture edge the live digits are exactly what gets latched.
            if ((state_nxt == LAP) && !lap_load) begin
                disp_d0 <= lap_d0;
                disp_d1 <= lap_d1;
                disp_d2 <= lap_d2;
                disp_d3 <= lap_d3;
            end else begin
                disp_d0 <= cnt_d0;
                disp_d1 <= cnt_d1;
                disp_d2 <= cnt_d2;
                disp_d3 <= cnt_d3;
            end
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4

module tb_stopwatch_ctrl;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_LAP     = 2'd3;

    logic       clk;
    logic       reset_n;
    logic       btn_ss;
    logic       btn_lr;
    logic [3:0] cnt_d0;
    logic [3:0] cnt_d1;
    logic [3:0] cnt_d2;
    logic [3:0] cnt_d3;
    logic       run;
    logic       clr;
    logic [3:0] disp_d0;
    logic [3:0] disp_d1;
    logic [3:0] disp_d2;
    logic [3:0] disp_d3;
    logic       lap_active;
    logic [1:0] state;
    logic [15:0] disp_all;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  st;
        logic        run;
        logic        lap;
        logic        clr;
        logic [15:0] disp;
    } exp_t;

    exp_t exp_q[$];

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .cnt_d0     (cnt_d0),
        .cnt_d1     (cnt_d1),
        .cnt_d2     (cnt_d2),
        .cnt_d3     (cnt_d3),
        .run        (run),
        .clr        (clr),
        .disp_d0    (disp_d0),
        .disp_d1    (disp_d1),
        .disp_d2    (disp_d2),
        .disp_d3    (disp_d3),
        .lap_active (lap_active),
        .state      (state)
    );

    assign disp_all = {disp_d3, disp_d2, disp_d1, disp_d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input logic [15:0] v);
        {cnt_d3, cnt_d2, cnt_d1, cnt_d0} = v;
    endtask

    task automatic expect_tr(input logic [1:0] st, input logic r, input logic l,
                             input logic c, input logic [15:0] d);
        exp_t e;
        e.st = st;
        e.run = r;
        e.lap = l;
        e.clr = c;
        e.disp = d;
        exp_q.push_back(e);
    endtask

    // Event must land exactly on the 7th edge after the raw rise / reset release.
    task automatic wait_transition(input string name, input int hold);
        logic [1:0] prev;
        bit         ok;
        exp_t       e;
        prev = state;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (state !== prev || clr !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_early actual=state %0d clr %0b required=state %0d clr 0", name, state, clr, prev);
        end
        tick();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_queue actual=empty required=entry", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL %s_state actual=%0d required=%0d", name, state, e.st);
            end
            checks++;
            if (run !== e.run) begin
                failures++;
                $display("FAIL %s_run actual=%0b required=%0b", name, run, e.run);
            end
            checks++;
            if (lap_active !== e.lap) begin
                failures++;
                $display("FAIL %s_lap actual=%0b required=%0b", name, lap_active, e.lap);
            end
            checks++;
            if (clr !== e.clr) begin
                failures++;
                $display("FAIL %s_clr actual=%0b required=%0b", name, clr, e.clr);
            end
            tick();
            checks++;
            if (clr !== 1'b0) begin
                failures++;
                $display("FAIL %s_clr_drop actual=%0b required=0", name, clr);
            end
            checks++;
            if (disp_all !== e.disp) begin
                failures++;
                $display("FAIL %s_disp actual=%h required=%h", name, disp_all, e.disp);
            end
            if (hold > 0) begin
                ok = 1'b1;
                for (int i = 0; i < hold; i++) begin
                    tick();
                    if (state !== e.st || clr !== 1'b0) ok = 1'b0;
                end
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL %s_hold actual=state %0d required=state %0d", name, state, e.st);
                end
            end
        end
    endtask

    task automatic settle(input string name, input int n);
        logic [1:0] prev;
        bit         ok;
        prev = state;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (state !== prev || clr !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_settle actual=state %0d clr %0b required=state %0d clr 0", name, state, clr, prev);
        end
    endtask

    task automatic press(input string name, input logic ss, input logic lr,
                         input logic [1:0] st, input logic r, input logic l,
                         input logic c, input logic [15:0] d);
        expect_tr(st, r, l, c, d);
        btn_ss = ss;
        btn_lr = lr;
        wait_transition(name, 0);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        settle(name, 10);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (state !== S_IDLE) begin
            failures++;
            $display("FAIL %s_state actual=%0d required=0", name, state);
        end
        checks++;
        if (run !== 1'b0 || clr !== 1'b0 || lap_active !== 1'b0) begin
            failures++;
            $display("FAIL %s_flags actual=run %0b clr %0b lap %0b required=0 0 0", name, run, clr, lap_active);
        end
        checks++;
        if (disp_all !== 16'h0000) begin
            failures++;
            $display("FAIL %s_disp actual=%h required=0000", name, disp_all);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        set_cnt(16'h0000);
        tick();
        tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_start();
        expect_tr(S_RUNNING, 1'b1, 1'b0, 1'b0, 16'h0000);
        btn_ss = 1'b1;
        wait_transition("start", 12);
        btn_ss = 1'b0;
        settle("start_release", 10);
    endtask

    task automatic test_display();
        set_cnt(16'h8765);
        checks++;
        if (disp_all !== 16'h0000) begin
            failures++;
            $display("FAIL disp_lat_before actual=%h required=0000", disp_all);
        end
        tick();
        checks++;
        if (disp_all !== 16'h8765) begin
            failures++;
            $display("FAIL disp_lat_after actual=%h required=8765", disp_all);
        end
    endtask

    task automatic test_lap();
        bit ok;
        set_cnt(16'h0123);
        tick();
        press("lap_in", 1'b0, 1'b1, S_LAP, 1'b1, 1'b1, 1'b0, 16'h0123);
        set_cnt(16'h0147);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (disp_all !== 16'h0123) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL lap_freeze actual=%h required=0123", disp_all);
        end
        press("lap_out", 1'b0, 1'b1, S_RUNNING, 1'b1, 1'b0, 1'b0, 16'h0147);
    endtask

    task automatic test_pause_clear();
        press("pause", 1'b1, 1'b0, S_PAUSED, 1'b0, 1'b0, 1'b0, 16'h0147);
        press("clear", 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0, 1'b1, 16'h0147);
        press("idle_clear", 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0, 1'b1, 16'h0147);
    endtask

    task automatic test_glitch();
        btn_ss = 1'b1;
        tick();
        tick();
        tick();
        btn_ss = 1'b0;
        settle("glitch", 12);
    endtask

    task automatic test_simultaneous();
        press("sim_run", 1'b1, 1'b0, S_RUNNING, 1'b1, 1'b0, 1'b0, 16'h0147);
        press("sim_pause", 1'b1, 1'b0, S_PAUSED, 1'b0, 1'b0, 1'b0, 16'h0147);
        press("sim_both", 1'b1, 1'b1, S_RUNNING, 1'b1, 1'b0, 1'b0, 16'h0147);
    endtask

    task automatic test_bounce();
        bit ok;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ok = 1'b1;
        for (int r = 0; r < 4; r++) begin
            btn_ss = 1'b1;
            tick();
            if (state !== S_IDLE) ok = 1'b0;
            tick();
            if (state !== S_IDLE) ok = 1'b0;
            btn_ss = 1'b0;
            tick();
            if (state !== S_IDLE) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bounce_quiet actual=%0d required=0", state);
        end
        expect_tr(S_RUNNING, 1'b1, 1'b0, 1'b0, 16'h0147);
        btn_ss = 1'b1;
        wait_transition("bounce", 4);
        btn_ss = 1'b0;
        settle("bounce_release", 10);
    endtask

    task automatic test_reset_mid();
        press("mid_lap", 1'b0, 1'b1, S_LAP, 1'b1, 1'b1, 1'b0, 16'h0147);
        btn_ss = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        tick();
        check_reset_values("mid_reset");
        reset_n = 1'b1;
        expect_tr(S_RUNNING, 1'b1, 1'b0, 1'b0, 16'h0147);
        wait_transition("mid_held", 6);
        btn_ss = 1'b0;
        settle("mid_release", 10);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_start();
        test_display();
        test_lap();
        test_pause_clear();
        test_glitch();
        test_simultaneous();
        test_bounce();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
